// File: rtl/posit_mult_seq.sv
// posit_mult_seq: sequential posit multiplier core.
//
// Takes two decoded posit operands and multiplies their mantissas with an
// iterative shift-add datapath, one multiplier bit per cycle. It adds the
// operand scales and hands a normalised sign/scale/mantissa result to the
// packing stage.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid / in_ready         operand handshake (in_ready only in idle)
//   Sign_x, Regime_x,           decoded operand fields, x in {a, b}
//   Exponent_x, Mantissa_x
//   Zero_x, NaR_x               operand special flags
//   out_valid / out_ready       result handshake
//   Sign_out, Scale_out,        normalised result, leading 1 of Mant_out at
//   Mant_out                    bit 2*MW-1
//   Zero_out, NaR_out           special-result flags
module posit_mult_seq #(
    parameter int unsigned N  = 8,
    parameter int unsigned ES = 3,
    parameter int unsigned RS = $clog2(N) + 1,
    parameter int unsigned MW = N - ES,
    parameter int unsigned SW = RS + ES + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 Sign_a,
    input  logic                 Sign_b,
    input  logic signed [RS-1:0] Regime_a,
    input  logic signed [RS-1:0] Regime_b,
    input  logic [ES-1:0]        Exponent_a,
    input  logic [ES-1:0]        Exponent_b,
    input  logic [MW-1:0]        Mantissa_a,
    input  logic [MW-1:0]        Mantissa_b,
    input  logic                 Zero_a,
    input  logic                 Zero_b,
    input  logic                 NaR_a,
    input  logic                 NaR_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 Sign_out,
    output logic signed [SW-1:0] Scale_out,
    output logic [2*MW-1:0]      Mant_out,
    output logic                 Zero_out,
    output logic                 NaR_out
);

    localparam int unsigned CW = (MW > 1) ? $clog2(MW) : 1;
    localparam logic [CW-1:0] CntLast = CW'(MW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StNorm,
        StSpecial,
        StDone
    } state_e;

    state_e                state_q;
    logic                  sign_a_q;
    logic                  sign_b_q;
    logic                  zero_q;
    logic                  nar_q;
    logic [MW-1:0]         mant_a_q;
    logic [MW-1:0]         mant_b_q;
    logic signed [SW-1:0]  scale_sum_q;
    logic [2*MW-1:0]       acc_q;
    logic [CW-1:0]         cnt_q;

    // Scale is Regime*2^ES + Exponent; since 0 <= Exponent < 2^ES this is just
    // the concatenation, with one extra sign bit so the sum of two fits in SW.
    logic signed [SW-1:0]  scale_a;
    logic signed [SW-1:0]  scale_b;
    logic [2*MW-1:0]       partial;

    assign scale_a = {Regime_a[RS-1], Regime_a, Exponent_a};
    assign scale_b = {Regime_b[RS-1], Regime_b, Exponent_b};
    assign partial = {{MW{1'b0}}, mant_a_q} << cnt_q;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            zero_q      <= 1'b0;
            nar_q       <= 1'b0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            scale_sum_q <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            Sign_out    <= 1'b0;
            Scale_out   <= '0;
            Mant_out    <= '0;
            Zero_out    <= 1'b0;
            NaR_out     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_a_q    <= Sign_a;
                        sign_b_q    <= Sign_b;
                        zero_q      <= Zero_a | Zero_b;
                        nar_q       <= NaR_a | NaR_b;
                        mant_a_q    <= Mantissa_a;
                        mant_b_q    <= Mantissa_b;
                        scale_sum_q <= scale_a + scale_b;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        if (Zero_a | Zero_b | NaR_a | NaR_b) begin
                            state_q <= StSpecial;
                        end else begin
                            state_q <= StMul;
                        end
                    end
                end
                StMul: begin
                    // Multiplier scanned LSB first; partial is mant_a aligned to bit cnt.
                    if (mant_b_q[cnt_q]) begin
                        acc_q <= acc_q + partial;
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CntLast) begin
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    // Product of two 1.f values lies in [1,4): at most one shift needed.
                    if (acc_q[2*MW-1]) begin
                        Mant_out  <= acc_q;
                        Scale_out <= scale_sum_q + SW'(1);
                    end else begin
                        Mant_out  <= acc_q << 1;
                        Scale_out <= scale_sum_q;
                    end
                    Sign_out <= sign_a_q ^ sign_b_q;
                    Zero_out <= 1'b0;
                    NaR_out  <= 1'b0;
                    state_q  <= StDone;
                end
                StSpecial: begin
                    NaR_out   <= nar_q;
                    Zero_out  <= zero_q & ~nar_q;
                    Sign_out  <= 1'b0;
                    Scale_out <= '0;
                    Mant_out  <= '0;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_mult_seq.sv
// Directed self-checking bench for posit_mult_seq (N=8, ES=3, MW=5, SW=8).
module tb_posit_mult_seq;

    localparam int unsigned N  = 8;
    localparam int unsigned ES = 3;
    localparam int unsigned RS = 4;
    localparam int unsigned MW = 5;
    localparam int unsigned SW = 8;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic                 Sign_a, Sign_b;
    logic signed [RS-1:0] Regime_a, Regime_b;
    logic [ES-1:0]        Exponent_a, Exponent_b;
    logic [MW-1:0]        Mantissa_a, Mantissa_b;
    logic                 Zero_a, Zero_b, NaR_a, NaR_b;
    logic                 out_valid;
    logic                 out_ready;
    logic                 Sign_out;
    logic signed [SW-1:0] Scale_out;
    logic [2*MW-1:0]      Mant_out;
    logic                 Zero_out, NaR_out;

    int nvec = 0;
    int nerr = 0;

    posit_mult_seq #(
        .N  (N),
        .ES (ES),
        .RS (RS),
        .MW (MW),
        .SW (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Sign_a     (Sign_a),
        .Sign_b     (Sign_b),
        .Regime_a   (Regime_a),
        .Regime_b   (Regime_b),
        .Exponent_a (Exponent_a),
        .Exponent_b (Exponent_b),
        .Mantissa_a (Mantissa_a),
        .Mantissa_b (Mantissa_b),
        .Zero_a     (Zero_a),
        .Zero_b     (Zero_b),
        .NaR_a      (NaR_a),
        .NaR_b      (NaR_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Sign_out   (Sign_out),
        .Scale_out  (Scale_out),
        .Mant_out   (Mant_out),
        .Zero_out   (Zero_out),
        .NaR_out    (NaR_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic sa, input int ra, input int ea, input logic [MW-1:0] ma,
                           input logic za, input logic na,
                           input logic sb, input int rb, input int eb, input logic [MW-1:0] mb,
                           input logic zb, input logic nb);
        Sign_a = sa; Regime_a = RS'(ra); Exponent_a = ES'(ea); Mantissa_a = ma;
        Zero_a = za; NaR_a = na;
        Sign_b = sb; Regime_b = RS'(rb); Exponent_b = ES'(eb); Mantissa_b = mb;
        Zero_b = zb; NaR_b = nb;
    endtask

    task automatic check_result(input string tag, input logic es, input int escale,
                                input logic [2*MW-1:0] em, input logic ez, input logic en);
        check({tag, ".sign"},  32'(Sign_out),  32'(es));
        check({tag, ".scale"}, 32'(Scale_out), 32'(escale));
        check({tag, ".mant"},  32'(Mant_out),  32'(em));
        check({tag, ".zero"},  32'(Zero_out),  32'(ez));
        check({tag, ".nar"},   32'(NaR_out),   32'(en));
    endtask

    // Operands must already be set. Latency counts the accepting edge as edge 1.
    // hold > 0 keeps out_ready low for that many DONE cycles with in_valid pulsed.
    task automatic run_op(input string tag, input logic es, input int escale,
                          input logic [2*MW-1:0] em, input logic ez, input logic en,
                          input int elat, input int hold);
        int edges;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".busy"}, 32'(in_ready), 32'(0));
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check({tag, ".latency"}, 32'(edges), 32'(elat));
        check_result(tag, es, escale, em, ez, en);
        for (int i = 0; i < hold; i++) begin
            set_ops(1'b1, 2, 1, 5'b11111, 1'b0, 1'b0, 1'b0, 1, 1, 5'b10101, 1'b0, 1'b0);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check({tag, ".hold_valid"}, 32'(out_valid), 32'(1));
            check({tag, ".hold_ready"}, 32'(in_ready), 32'(0));
            check_result({tag, ".hold"}, es, escale, em, ez, en);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, 32'(out_valid), 32'(0));
        check({tag, ".post_ready"}, 32'(in_ready), 32'(1));
        check({tag, ".post_mant"},  32'(Mant_out), 32'(em));
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_ops(1'b0, 0, 0, 5'b10000, 1'b0, 1'b0, 1'b0, 0, 0, 5'b10000, 1'b0, 1'b0);
        #12;
        check("rst.in_ready", 32'(in_ready), 32'(1));
        check("rst.out_valid", 32'(out_valid), 32'(0));
        check_result("rst", 1'b0, 0, 10'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1.0 x 1.0: 16*16 = 0100000000, shift once
        set_ops(1'b0, 0, 0, 5'b10000, 1'b0, 1'b0, 1'b0, 0, 0, 5'b10000, 1'b0, 1'b0);
        run_op("one", 1'b0, 0, 10'b1000000000, 1'b0, 1'b0, 7, 0);

        // 1.5 x -1.5: 24*24 = 576 = 1001000000, no shift, scale +1
        set_ops(1'b0, 0, 0, 5'b11000, 1'b0, 1'b0, 1'b1, 0, 0, 5'b11000, 1'b0, 1'b0);
        run_op("p15", 1'b1, 1, 10'b1001000000, 1'b0, 1'b0, 7, 0);

        // Scale 10 + (-11) = -1
        set_ops(1'b0, 1, 2, 5'b10000, 1'b0, 1'b0, 1'b0, -2, 5, 5'b10000, 1'b0, 1'b0);
        run_op("scale", 1'b0, -1, 10'b1000000000, 1'b0, 1'b0, 7, 0);

        // Max mantissas and scales: 31*31 = 961 = 1111000001; 31+31+1 = 63
        set_ops(1'b1, 3, 7, 5'b11111, 1'b0, 1'b0, 1'b1, 3, 7, 5'b11111, 1'b0, 1'b0);
        run_op("max", 1'b0, 63, 10'b1111000001, 1'b0, 1'b0, 7, 0);

        // Min scales -64 + -64 = -128; 16*17 = 272 = 0100010000 -> 1000100000
        set_ops(1'b0, -8, 0, 5'b10000, 1'b0, 1'b0, 1'b0, -8, 0, 5'b10001, 1'b0, 1'b0);
        run_op("min", 1'b0, -128, 10'b1000100000, 1'b0, 1'b0, 7, 0);

        // NaR wins over zero
        set_ops(1'b1, 2, 3, 5'b11000, 1'b0, 1'b1, 1'b0, 0, 0, 5'b10000, 1'b1, 1'b0);
        run_op("nar", 1'b0, 0, 10'b0, 1'b0, 1'b1, 2, 0);

        // Zero_a only, nonzero other fields
        set_ops(1'b1, 3, 5, 5'b11100, 1'b1, 1'b0, 1'b0, 1, 1, 5'b10100, 1'b0, 1'b0);
        run_op("zero", 1'b0, 0, 10'b0, 1'b1, 1'b0, 2, 0);

        // Backpressure with ignored in_valid pulses
        set_ops(1'b0, 0, 0, 5'b11000, 1'b0, 1'b0, 1'b1, 0, 0, 5'b11000, 1'b0, 1'b0);
        run_op("bp", 1'b1, 1, 10'b1001000000, 1'b0, 1'b0, 7, 3);
        tick();
        check("bp.idle_valid", 32'(out_valid), 32'(0));
        check("bp.idle_ready", 32'(in_ready), 32'(1));

        // Reset during the third MUL cycle
        set_ops(1'b0, 0, 0, 5'b11000, 1'b0, 1'b0, 1'b0, 0, 0, 5'b11000, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mrst.out_valid", 32'(out_valid), 32'(0));
        check("mrst.in_ready", 32'(in_ready), 32'(1));
        check_result("mrst", 1'b0, 0, 10'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        set_ops(1'b0, 0, 0, 5'b10000, 1'b0, 1'b0, 1'b0, 0, 0, 5'b10000, 1'b0, 1'b0);
        run_op("after", 1'b0, 0, 10'b1000000000, 1'b0, 1'b0, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
